// File: rtl/layer_4_input_streamer.sv
// Channel-serial to channel-parallel packer for the layer-4 feature-map engine.
// Assembles NUM_CH float words per pixel and walks an IMG_SIZE x IMG_SIZE raster.
module layer_4_input_streamer #(
   parameter  int DATA_WIDTH    = 32,
   parameter  int NUM_CH        = 32,
   parameter  int DATA_IN_WIDTH = 1024,
   parameter  int IMG_SIZE      = 104,
   localparam int CW            = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     start,
   input  logic [DATA_WIDTH-1:0]    s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [DATA_IN_WIDTH-1:0] data_out,
   output logic                     valid_out,
   output logic [CW-1:0]            col,
   output logic [CW-1:0]            row,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

   state_t                     r_state;
   logic                       r_s_ready;
   logic                       r_busy;
   logic                       r_valid_out;
   logic                       r_frame_done;
   logic [DATA_IN_WIDTH-1:0]   r_data_out;
   logic [CW-1:0]              r_col;
   logic [CW-1:0]              r_row;
   logic [CW-1:0]              r_pix_col;
   logic [CW-1:0]              r_pix_row;
   logic [CHW-1:0]             r_ch_cnt;
   logic [DATA_WIDTH-1:0]      r_shadow [NUM_CH-1];

   logic                       w_accept;
   logic                       w_last_ch;
   logic                       w_col_end;
   logic                       w_row_end;
   logic [DATA_IN_WIDTH-1:0]   w_packed;

   // The final channel bypasses the shadow and goes straight into the packed word.
   always_comb begin
      w_accept  = s_valid && r_s_ready;
      w_last_ch = (r_ch_cnt == CHW'(NUM_CH - 1));
      w_col_end = (r_pix_col == CW'(IMG_SIZE - 1));
      w_row_end = (r_pix_row == CW'(IMG_SIZE - 1));
      w_packed  = '0;
      for (int unsigned i = 0; i < NUM_CH - 1; i++) begin
         w_packed[i*DATA_WIDTH +: DATA_WIDTH] = r_shadow[i];
      end
      w_packed[(NUM_CH-1)*DATA_WIDTH +: DATA_WIDTH] = s_data;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state      <= IDLE;
         r_s_ready    <= 1'b0;
         r_busy       <= 1'b0;
         r_valid_out  <= 1'b0;
         r_frame_done <= 1'b0;
         r_data_out   <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_pix_col    <= '0;
         r_pix_row    <= '0;
         r_ch_cnt     <= '0;
         for (int unsigned i = 0; i < NUM_CH - 1; i++) begin
            r_shadow[i] <= '0;
         end
      end else begin
         r_valid_out  <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_ch_cnt  <= '0;
               r_pix_col <= '0;
               r_pix_row <= '0;
               if (start) begin
                  r_state   <= PACK;
                  r_s_ready <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            PACK: begin
               if (w_accept) begin
                  if (w_last_ch) begin
                     r_ch_cnt    <= '0;
                     r_data_out  <= w_packed;
                     r_valid_out <= 1'b1;
                     r_col       <= r_pix_col;
                     r_row       <= r_pix_row;
                     if (w_col_end) begin
                        r_pix_col <= '0;
                        if (w_row_end) begin
                           r_pix_row    <= '0;
                           r_state      <= DONE;
                           r_s_ready    <= 1'b0;
                           r_frame_done <= 1'b1;
                        end else begin
                           r_pix_row <= r_pix_row + 1'b1;
                        end
                     end else begin
                        r_pix_col <= r_pix_col + 1'b1;
                     end
                  end else begin
                     for (int unsigned i = 0; i < NUM_CH - 1; i++) begin
                        if (r_ch_cnt == CHW'(i)) begin
                           r_shadow[i] <= s_data;
                        end
                     end
                     r_ch_cnt <= r_ch_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state   <= IDLE;
               r_s_ready <= 1'b0;
               r_busy    <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready    = r_s_ready;
   assign busy       = r_busy;
   assign valid_out  = r_valid_out;
   assign frame_done = r_frame_done;
   assign data_out   = r_data_out;
   assign col        = r_col;
   assign row        = r_row;

endmodule

// File: tb/tb_layer_4_input_streamer.sv
// Directed bench: a 1x1-frame build and a 4x4-frame build share clock, reset and data.
module tb_layer_4_input_streamer;

   localparam int DW  = 32;
   localparam int NCH = 32;
   localparam int DIW = 1024;

   logic           Clk = 1'b0;
   logic           Rst = 1'b1;
   logic           start1 = 1'b0;
   logic           start4 = 1'b0;
   logic           s_valid = 1'b0;
   logic [DW-1:0]  s_data = '0;

   logic           s_ready1, valid_out1, busy1, frame_done1;
   logic [DIW-1:0] data_out1;
   logic [0:0]     col1, row1;
   logic           s_ready4, valid_out4, busy4, frame_done4;
   logic [DIW-1:0] data_out4;
   logic [1:0]     col4, row4;

   int n_vec = 0;
   int n_err = 0;

   layer_4_input_streamer #(
      .DATA_WIDTH(DW), .NUM_CH(NCH), .DATA_IN_WIDTH(DIW), .IMG_SIZE(1)
   ) u_dut1 (
      .Clk(Clk), .Rst(Rst), .start(start1), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready1), .data_out(data_out1), .valid_out(valid_out1),
      .col(col1), .row(row1), .busy(busy1), .frame_done(frame_done1)
   );

   layer_4_input_streamer #(
      .DATA_WIDTH(DW), .NUM_CH(NCH), .DATA_IN_WIDTH(DIW), .IMG_SIZE(4)
   ) u_dut4 (
      .Clk(Clk), .Rst(Rst), .start(start4), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready4), .data_out(data_out4), .valid_out(valid_out4),
      .col(col4), .row(row4), .busy(busy4), .frame_done(frame_done4)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic g_ready(input bit sel);
      return sel ? s_ready1 : s_ready4;
   endfunction
   function automatic logic g_valid(input bit sel);
      return sel ? valid_out1 : valid_out4;
   endfunction
   function automatic logic g_fd(input bit sel);
      return sel ? frame_done1 : frame_done4;
   endfunction
   function automatic logic g_busy(input bit sel);
      return sel ? busy1 : busy4;
   endfunction
   function automatic logic [7:0] g_col(input bit sel);
      return sel ? 8'(col1) : 8'(col4);
   endfunction
   function automatic logic [7:0] g_row(input bit sel);
      return sel ? 8'(row1) : 8'(row4);
   endfunction
   function automatic logic [31:0] g_word(input bit sel, input int k);
      return sel ? data_out1[k*DW +: DW] : data_out4[k*DW +: DW];
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic start_frame(input bit sel);
      if (sel) start1 = 1'b1; else start4 = 1'b1;
      tick();
      start1 = 1'b0;
      start4 = 1'b0;
      chk("s_ready after start", g_ready(sel), 1);
      chk("busy after start", g_busy(sel), 1);
   endtask

   // Drives one word after 'gap' idle cycles; returns whether it was accepted.
   task automatic send_word(input bit sel, input logic [31:0] w, input int gap, output bit acc);
      int waitc;
      for (int g = 0; g < gap; g++) begin
         s_valid = 1'b0;
         tick();
         chk("no valid while stalled", g_valid(sel), 0);
      end
      s_valid = 1'b1;
      s_data  = w;
      waitc   = 0;
      do begin
         acc = g_ready(sel);
         tick();
         waitc++;
      end while (!acc && waitc < 8);
      s_valid = 1'b0;
      chk("word accepted", acc, 1);
   endtask

   task automatic send_pixel(input bit sel, input logic [31:0] base, input int pcol,
                             input int prow, input bit fd, input int gapmax);
      bit acc;
      for (int k = 0; k < NCH; k++) begin
         int gap;
         gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
         send_word(sel, base + 32'(k), gap, acc);
         if (!acc) return;
         if (k < NCH - 1) chk("no valid mid-pixel", g_valid(sel), 0);
      end
      chk($sformatf("valid_out px(%0d,%0d)", prow, pcol), g_valid(sel), 1);
      chk($sformatf("frame_done px(%0d,%0d)", prow, pcol), g_fd(sel), 64'(fd));
      chk($sformatf("col px(%0d,%0d)", prow, pcol), g_col(sel), 64'(pcol));
      chk($sformatf("row px(%0d,%0d)", prow, pcol), g_row(sel), 64'(prow));
      for (int k = 0; k < NCH; k++) begin
         chk($sformatf("data ch%0d px(%0d,%0d)", k, prow, pcol), g_word(sel, k), base + 32'(k));
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " s_ready1"}, s_ready1, 0);
      chk({tag, " valid1"}, valid_out1, 0);
      chk({tag, " busy1"}, busy1, 0);
      chk({tag, " fd1"}, frame_done1, 0);
      chk({tag, " data1"}, 64'(|data_out1), 0);
      chk({tag, " s_ready4"}, s_ready4, 0);
      chk({tag, " valid4"}, valid_out4, 0);
      chk({tag, " busy4"}, busy4, 0);
      chk({tag, " fd4"}, frame_done4, 0);
      chk({tag, " data4"}, 64'(|data_out4), 0);
      chk({tag, " col4"}, 64'(col4), 0);
      chk({tag, " row4"}, 64'(row4), 0);
   endtask

   function automatic logic [31:0] px_base(input int p);
      return 32'h4000_0000 + 32'(p << 8);
   endfunction

   initial begin
      bit acc;

      // Reset, then words offered while idle must be ignored.
      repeat (3) tick();
      chk_reset_state("reset");
      Rst = 1'b0;
      s_valid = 1'b1;
      s_data  = 32'hBAD0_0000;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle s_ready4", s_ready4, 0);
         chk("idle valid4", valid_out4, 0);
         chk("idle s_ready1", s_ready1, 0);
      end
      s_valid = 1'b0;

      // Single-pixel frame on the 1x1 build.
      start_frame(1'b1);
      send_pixel(1'b1, 32'h3F80_0000, 0, 0, 1'b1, 0);
      chk("single DONE busy", busy1, 1);
      chk("single DONE s_ready", s_ready1, 0);
      tick();
      chk("single idle busy", busy1, 0);
      chk("single idle valid", valid_out1, 0);
      chk("single idle fd", frame_done1, 0);

      // Full 4x4 raster, back-to-back words.
      start_frame(1'b0);
      for (int p = 0; p < 16; p++) begin
         send_pixel(1'b0, px_base(p), p % 4, p / 4, p == 15, 0);
      end
      tick();
      chk("raster idle busy", busy4, 0);
      chk("raster idle s_ready", s_ready4, 0);
      chk("raster hold col", 64'(col4), 3);
      chk("raster hold row", 64'(row4), 3);

      // Same frame with random gaps: identical packed contents expected.
      start_frame(1'b0);
      for (int p = 0; p < 16; p++) begin
         send_pixel(1'b0, px_base(p), p % 4, p / 4, p == 15, 5);
      end
      tick();

      // Reset partway through a pixel; the aborted pixel must never emerge.
      start_frame(1'b0);
      for (int k = 0; k < 17; k++) begin
         send_word(1'b0, 32'hDEAD_0000 + 32'(k), 0, acc);
      end
      Rst = 1'b1;
      #1;
      chk_reset_state("mid-pixel reset");
      tick();
      chk("reset held valid4", valid_out4, 0);
      Rst = 1'b0;
      tick();
      start_frame(1'b0);
      send_pixel(1'b0, 32'h5000_0000, 0, 0, 1'b0, 0);

      // Starts during PACK and DONE are ignored; start after DONE restarts at (0,0).
      for (int p = 1; p < 16; p++) begin
         if (p == 3 || p == 9) start4 = 1'b1;
         send_pixel(1'b0, px_base(p) ^ 32'h0F00_0000, p % 4, p / 4, p == 15, 1);
         start4 = 1'b0;
      end
      start4 = 1'b1;
      tick();
      chk("start in DONE ignored", s_ready4, 0);
      chk("idle after DONE busy", busy4, 0);
      tick();
      start4 = 1'b0;
      chk("restart s_ready", s_ready4, 1);
      send_pixel(1'b0, 32'h6000_0000, 0, 0, 1'b0, 0);

      Rst = 1'b1;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/layer_4_input_streamer.md
# layer_4_input_streamer

Channel-packing front end for a layer-4 feature-map engine. It accepts one 32-bit float word per cycle from an upstream channel-serial source under a valid/ready handshake. It assembles the 32 channel words of each pixel into a 1024-bit channel-parallel word and presents it with a one-cycle valid pulse on the `data_in`/`valid_in` interface of the feature-map instances. It tracks raster position over an IMG_SIZE×IMG_SIZE frame and signals frame completion.

## Interface
- DATA_WIDTH, 32, width of one channel word (IEEE-754 single)
- NUM_CH, 32, channels packed per pixel
- DATA_IN_WIDTH, 1024, packed output width (= DATA_WIDTH×NUM_CH)
- IMG_SIZE, 104, frame width and height in pixels

Ports:
- Clk  in  1  clock; one clock domain; all logic on rising edge
- Rst  in  1  reset; asynchronous, active-high
- start  in  1  arms one frame; sampled only in IDLE
- s_data  in  DATA_WIDTH  channel word; channel 0 first
- s_valid  in  1  s_data valid
- s_ready  out  1  streamer accepts s_data this cycle
- data_out  out  DATA_IN_WIDTH  packed pixel; channel k at bits [32k+31:32k]
- valid_out  out  1  one-cycle pulse, data_out holds a new pixel
- col  out  clog2(IMG_SIZE)  column of the pixel on data_out
- row  out  clog2(IMG_SIZE)  row of the pixel on data_out
- busy  out  1  high in PACK and DONE
- frame_done  out  1  one-cycle pulse with the last pixel's valid_out

## Operation
- States: IDLE, PACK, DONE.
  - IDLE: s_ready=0. start=1 → PACK. Channel, column and row counters clear to 0.
  - PACK: s_ready=1. Each accepted word (s_valid&&s_ready) is written to the shadow register slot ch_cnt, then ch_cnt increments.
  - On acceptance with ch_cnt=NUM_CH-1:
    - ch_cnt wraps to 0.
    - shadow slots 0..30 plus the current word load into data_out.
    - valid_out pulses next cycle.
    - col/row update to that pixel's coordinates.
  - Pixel counter advances raster-order: col increments; at IMG_SIZE-1 col wraps to 0 and row increments.
  - Acceptance completing pixel (IMG_SIZE-1, IMG_SIZE-1) → DONE.
  - DONE: lasts exactly one cycle, s_ready=0, then → IDLE.
- start while in PACK or DONE is ignored.
- s_valid=0 in PACK stalls packing indefinitely. No timeout. State and counters hold.
- No downstream backpressure. Consumers sample data_out only on valid_out.
- data_out, col and row hold their last value until the next pixel completes.
- Data is passed bit-exact. No arithmetic on the payload.

## Timing
- Reset values:
  - state=IDLE
  - s_ready=0, valid_out=0, frame_done=0, busy=0
  - data_out=0, col=0, row=0
  - ch_cnt=0, shadow register=0
- Rst asserted mid-frame: immediate return to reset values. The partial pixel is discarded; no valid_out is emitted for it.
- s_ready is a registered function of state. It goes high the cycle after start is sampled in IDLE.
- Latency: last channel word accepted at cycle N → valid_out, data_out, col, row updated at N+1.
- frame_done is coincident with the final valid_out (cycle N+1). State is DONE that cycle and IDLE at N+2. A new start is accepted from N+2.
- Minimum pixel spacing is NUM_CH cycles, so valid_out is never high on consecutive cycles.
- busy is high from the cycle s_ready rises through the DONE cycle inclusive.

## Test plan
- Reset/idle:
  - Stimulus: assert Rst mid-run; then drive s_valid=1 in IDLE.
  - Required: all outputs at reset values; s_ready stays 0; no word is accepted and no valid_out.
- Single pixel (IMG_SIZE=1 build):
  - Stimulus: start, then 32 words 0x3F800000+k back-to-back.
  - Required: valid_out exactly 1 cycle after the 32nd word; data_out[32k+31:32k]=0x3F800000+k; frame_done coincident; IDLE 2 cycles after.
- Raster order (IMG_SIZE=4):
  - Stimulus: full frame of 512 words.
  - Required: 16 valid_out pulses with (row,col) from (0,0) to (3,3), col wrapping after 3; frame_done only with (3,3).
- Stalls:
  - Stimulus: random s_valid gaps of 0–5 cycles.
  - Required: packed contents identical to the no-stall run; no valid_out while stalled.
- Reset mid-pixel:
  - Stimulus: Rst after 17 words, then start and a full pixel.
  - Required: no valid_out for the aborted pixel; the next pixel packs from channel 0 at (0,0).
- Start ignored:
  - Stimulus: start pulses during PACK and DONE.
  - Required: no restart, counters unaffected; start one cycle after DONE begins a new frame at (0,0).
